// File: rtl/pipe_skid_buf.sv
// Two-entry elastic pipeline register with a registered ready toward upstream,
// a skid entry to absorb the late backpressure, and a saturating stall counter.
//
//  state | meaning
//  EMPTY | nothing held, m_valid_o=0, s_ready_o=1
//  ONE   | head entry in main, m_valid_o=1, s_ready_o=1
//  TWO   | head in main, overflow in skid, m_valid_o=1, s_ready_o=0
module pipe_skid_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic [1:0]       occ_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  main_q;
    logic [WIDTH-1:0]  skid_q;
    logic [CNT_W-1:0]  stall_q;
    logic              in_xfer;
    logic              out_xfer;

    // every output decodes straight from registers
    assign m_valid_o   = (state != EMPTY);
    assign s_ready_o   = (state != TWO);
    assign occ_o       = state;
    assign m_data_o    = main_q;
    assign stall_cnt_o = stall_q;

    assign in_xfer  = s_valid_i & s_ready_o;
    assign out_xfer = m_valid_o & m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            if (m_valid_o && !m_ready_i && !flush_i && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;

            if (flush_i) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_q <= s_data_i;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_q <= s_data_i;
                        end else if (out_xfer) begin
                            state <= EMPTY;
                        end else if (in_xfer) begin
                            skid_q <= s_data_i;
                            state  <= TWO;
                        end
                    end
                    TWO: begin
                        if (out_xfer) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf: directed sequences with hand-computed values plus a
// FIFO scoreboard fed by accepted inputs and drained by a negedge monitor.
module tb_pipe_skid_buf;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       occ;
    logic [CNT_W-1:0] stall_cnt;

    // small-counter instance used to reach saturation quickly
    logic             s_valid_s = 1'b0;
    logic             m_ready_s = 1'b0;
    logic             flush_s = 1'b0;
    logic [7:0]       s_data_s = '0;
    logic             s_ready_s;
    logic             m_valid_s;
    logic [7:0]       m_data_s;
    logic [1:0]       occ_s;
    logic [3:0]       stall_cnt_s;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_skid_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .occ_o(occ), .stall_cnt_o(stall_cnt)
    );

    pipe_skid_buf #(.WIDTH(8), .CNT_W(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_s),
        .s_valid_i(s_valid_s), .s_ready_o(s_ready_s), .s_data_i(s_data_s),
        .m_valid_o(m_valid_s), .m_ready_i(m_ready_s), .m_data_o(m_data_s),
        .occ_o(occ_s), .stall_cnt_o(stall_cnt_s)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop/compare on output transfers, push accepted inputs, check stall stability.
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] data_prev = '0;
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("stall_valid_hold", longint'(m_valid), 1);
                chk("stall_data_hold", longint'(m_data), longint'(data_prev));
            end
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    chk("pop_on_empty_sb", 1, 0);
                end else begin
                    chk("sb_order", longint'(m_data), longint'(sb_q.pop_front()));
                end
            end
            if (s_valid && s_ready)
                sb_q.push_back(s_data);
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
        end
    end

    initial begin
        // reset
        step(); step();
        chk("rst_m_valid", longint'(m_valid), 0);
        chk("rst_s_ready", longint'(s_ready), 1);
        chk("rst_m_data", longint'(m_data), 0);
        chk("rst_occ", longint'(occ), 0);
        chk("rst_stall", longint'(stall_cnt), 0);
        rst = 1'b0;

        // streaming at full rate
        m_ready = 1'b1; s_valid = 1'b1;
        s_data = 32'h11; step();
        chk("str_d11", longint'(m_data), 32'h11); chk("str_occ1", longint'(occ), 1);
        s_data = 32'h22; step();
        chk("str_d22", longint'(m_data), 32'h22); chk("str_rdy", longint'(s_ready), 1);
        s_data = 32'h33; step();
        chk("str_d33", longint'(m_data), 32'h33); chk("str_occ3", longint'(occ), 1);
        s_valid = 1'b0; step();
        chk("str_drain_occ", longint'(occ), 0);
        chk("str_stall", longint'(stall_cnt), 0);

        // backpressure fills the skid entry
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 32'hA; step();
        chk("bp_occ1", longint'(occ), 1); chk("bp_dA", longint'(m_data), 32'hA);
        s_data = 32'hB; step();
        chk("bp_occ2", longint'(occ), 2); chk("bp_rdy0", longint'(s_ready), 0);
        chk("bp_stall1", longint'(stall_cnt), 1);
        s_data = 32'hC; step();
        chk("bp_hold_occ", longint'(occ), 2); chk("bp_hold_dA", longint'(m_data), 32'hA);
        chk("bp_stall2", longint'(stall_cnt), 2);
        m_ready = 1'b1; step();
        chk("bp_pop_dB", longint'(m_data), 32'hB); chk("bp_rdy1", longint'(s_ready), 1);
        chk("bp_pop_occ", longint'(occ), 1); chk("bp_stall_keep", longint'(stall_cnt), 2);
        step();
        chk("bp_dC", longint'(m_data), 32'hC);
        s_valid = 1'b0; step();
        chk("bp_empty", longint'(occ), 0);

        // flush while full
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 32'h5; step();
        s_data = 32'h6; step();
        chk("fl_occ2", longint'(occ), 2); chk("fl_stall3", longint'(stall_cnt), 3);
        flush = 1'b1; s_data = 32'h7; step();
        chk("fl_occ0", longint'(occ), 0); chk("fl_valid0", longint'(m_valid), 0);
        chk("fl_stall_keep", longint'(stall_cnt), 3);
        flush = 1'b0; s_valid = 1'b0; step();
        chk("fl_no7", longint'(occ), 0);

        // reset mid-operation
        s_valid = 1'b1; s_data = 32'h99; step();
        chk("rm_occ1", longint'(occ), 1);
        rst = 1'b1; s_data = 32'h77; step();
        chk("rm_valid", longint'(m_valid), 0); chk("rm_data", longint'(m_data), 0);
        chk("rm_rdy", longint'(s_ready), 1); chk("rm_occ", longint'(occ), 0);
        chk("rm_stall", longint'(stall_cnt), 0);
        rst = 1'b0; s_valid = 1'b0; step();
        chk("rm_after", longint'(occ), 0);

        // saturation on the 4-bit counter instance
        s_valid_s = 1'b1; s_data_s = 8'h5A; step();
        s_valid_s = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("sat_14", longint'(stall_cnt_s), 14);
        step();
        chk("sat_15", longint'(stall_cnt_s), 15);
        for (int i = 0; i < 5; i++) step();
        chk("sat_hold", longint'(stall_cnt_s), 15);
        chk("sat_data", longint'(m_data_s), 8'h5A);

        // random traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            s_data  = $urandom();
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rand_drain_occ", longint'(occ), 0);
        chk("rand_sb_empty", longint'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
